// File: rtl/gray_onehot_pkg.sv
// Shared types and code-word helpers for the gray/one-hot generator and decoder.
package gray_onehot_pkg;

    localparam int CODE_W = 7;
    localparam int BIN_W  = 3;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [BIN_W-1:0]  bin_t;

    function automatic bin_t gray2bin(input logic [BIN_W-1:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    // Shifted one-hot: all zeros is 0, bit k set is k+1; highest set bit wins.
    function automatic bin_t onehot2bin(input code_t c);
        bin_t b;
        b = '0;
        for (int k = 0; k < CODE_W; k++) begin
            if (c[k]) b = bin_t'(k + 1);
        end
        return b;
    endfunction

    function automatic logic onehot_multi(input code_t c);
        return (c & (c - 7'd1)) != '0;
    endfunction

endpackage

// File: rtl/goh_decode_core.sv
// Combinational code-word decode and legality check; illegal words decode to 0.
module goh_decode_core
    import gray_onehot_pkg::*;
#(
    parameter bit USE_GRAY = 1'b1
) (
    input  code_t i_code,
    output bin_t  o_bin,
    output logic  o_err
);

    always_comb begin
        o_bin = '0;
        o_err = 1'b0;
        if (USE_GRAY) begin
            o_err = |i_code[6:3];
            o_bin = gray2bin(i_code[2:0]);
        end else begin
            o_err = onehot_multi(i_code);
            o_bin = onehot2bin(i_code);
        end
        if (o_err) o_bin = '0;
    end

endmodule

// File: rtl/gray_onehot_decoder.sv
// Two-stage registered gray/one-hot to binary decoder with valid/ready handshake.
// Optional saturating illegal-word counter enabled by GOH_DEC_ERR_CNT_EN.
module gray_onehot_decoder
    import gray_onehot_pkg::*;
#(
    parameter bit USE_GRAY = 1'b1
`ifdef GOH_DEC_ERR_CNT_EN
    ,
    parameter int CNT_W    = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2:0]       out_bin,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
`ifdef GOH_DEC_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    logic  r_s1_valid;
    code_t r_s1_code;
    logic  r_s2_valid;
    bin_t  r_s2_bin;
    logic  r_s2_err;

    logic  w_s2_adv;
    logic  w_s1_adv;
    bin_t  w_bin;
    logic  w_err;

    // Handshake: a word moves on a rising edge when valid && ready. Stage 2
    // advances when empty or drained this edge; stage 1 only moves behind it,
    // so in_ready is combinational from out_ready and nothing is lost.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = r_s1_valid && w_s2_adv;
    assign in_ready = !r_s1_valid || w_s2_adv;

    goh_decode_core #(
        .USE_GRAY (USE_GRAY)
    ) u_core (
        .i_code (r_s1_code),
        .o_bin  (w_bin),
        .o_err  (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) r_s1_code <= in_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_bin   <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (w_s1_adv) begin
                r_s2_bin <= w_bin;
                r_s2_err <= w_err;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_bin   = r_s2_bin;
    assign out_err   = r_s2_err;

`ifdef GOH_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    // Counts only delivered words, so a held illegal word is counted once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (r_s2_valid && out_ready && r_s2_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_gray_onehot_decoder.sv
// Directed bench for gray_onehot_decoder: one gray instance (index 0) and one one-hot instance (index 1).
module tb_gray_onehot_decoder;

    typedef struct packed {
        logic [2:0]  bin;
        logic        err;
        logic [31:0] acc;
    } exp_t;

    typedef struct {
        int         dut;
        logic [6:0] code;
        logic [2:0] bin;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] in_code   [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [2:0] out_bin   [2];
    logic       out_err   [2];
    logic       out_valid [2];
    logic       out_ready [2];
`ifdef GOH_DEC_ERR_CNT_EN
    logic [1:0] err_cnt_g;
    logic [7:0] err_cnt_o;
`endif

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t mon_x;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   chk_lat;
    bit   hold   [2];
    logic [2:0] hold_bin [2];
    logic       hold_err [2];
    vec_t vecs [20];

    gray_onehot_decoder #(
        .USE_GRAY (1'b1)
`ifdef GOH_DEC_ERR_CNT_EN
        , .CNT_W (2)
`endif
    ) dut_g (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_code   (in_code[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .out_bin   (out_bin[0]),
        .out_err   (out_err[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0])
`ifdef GOH_DEC_ERR_CNT_EN
        , .err_cnt (err_cnt_g)
`endif
    );

    gray_onehot_decoder #(
        .USE_GRAY (1'b0)
`ifdef GOH_DEC_ERR_CNT_EN
        , .CNT_W (8)
`endif
    ) dut_o (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_code   (in_code[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .out_bin   (out_bin[1]),
        .out_err   (out_err[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1])
`ifdef GOH_DEC_ERR_CNT_EN
        , .err_cnt (err_cnt_o)
`endif
    );

    // Clock / cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: every output transfer is matched against the expected queue;
    // a held output must stay stable until it is taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold[0] <= 1'b0;
            hold[1] <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (hold[d]) begin
                    chk("hold_valid", 32'(out_valid[d]), 32'd1);
                    chk("hold_bin", 32'(out_bin[d]), 32'(hold_bin[d]));
                    chk("hold_err", 32'(out_err[d]), 32'(hold_err[d]));
                end
                if (out_valid[d] && out_ready[d]) begin
                    if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        chk("unexpected_word", 32'(out_bin[d]), 32'hFFFF_FFFF);
                    end else begin
                        mon_x = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk(d == 0 ? "gray_bin" : "oh_bin", 32'(out_bin[d]), 32'(mon_x.bin));
                        chk(d == 0 ? "gray_err" : "oh_err", 32'(out_err[d]), 32'(mon_x.err));
                        if (chk_lat) chk("latency", 32'(cyc) - mon_x.acc, 32'd2);
                    end
                end
                hold[d]     <= out_valid[d] && !out_ready[d];
                hold_bin[d] <= out_bin[d];
                hold_err[d] <= out_err[d];
            end
        end
    end

    // Driver: present a word, wait (bounded) for in_ready, queue its expectation.
    task automatic drive(input int d, input logic [6:0] code, input logic [2:0] b, input logic e);
        exp_t x;
        bit   ok;
        ok = 1'b0;
        in_code[d]  = code;
        in_valid[d] = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                ok    = 1'b1;
                x.bin = b;
                x.err = e;
                x.acc = 32'(cyc);
                if (d == 0) exp_q0.push_back(x);
                else        exp_q1.push_back(x);
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain_check();
        repeat (6) @(posedge clk);
        #1;
        chk("gray_queue_empty", 32'(exp_q0.size()), 32'd0);
        chk("oh_queue_empty", 32'(exp_q1.size()), 32'd0);
    endtask

    initial begin
        // Vector table: gray sweep, gray illegal, one-hot sweep, one-hot illegal.
        vecs[0]  = '{0, 7'b0000000, 3'd0, 1'b0};
        vecs[1]  = '{0, 7'b0000001, 3'd1, 1'b0};
        vecs[2]  = '{0, 7'b0000011, 3'd2, 1'b0};
        vecs[3]  = '{0, 7'b0000010, 3'd3, 1'b0};
        vecs[4]  = '{0, 7'b0000110, 3'd4, 1'b0};
        vecs[5]  = '{0, 7'b0000111, 3'd5, 1'b0};
        vecs[6]  = '{0, 7'b0000101, 3'd6, 1'b0};
        vecs[7]  = '{0, 7'b0000100, 3'd7, 1'b0};
        vecs[8]  = '{0, 7'b0001000, 3'd0, 1'b1};
        vecs[9]  = '{0, 7'b1111111, 3'd0, 1'b1};
        vecs[10] = '{1, 7'b0000000, 3'd0, 1'b0};
        vecs[11] = '{1, 7'b0000001, 3'd1, 1'b0};
        vecs[12] = '{1, 7'b0000010, 3'd2, 1'b0};
        vecs[13] = '{1, 7'b0000100, 3'd3, 1'b0};
        vecs[14] = '{1, 7'b0001000, 3'd4, 1'b0};
        vecs[15] = '{1, 7'b0010000, 3'd5, 1'b0};
        vecs[16] = '{1, 7'b0100000, 3'd6, 1'b0};
        vecs[17] = '{1, 7'b1000000, 3'd7, 1'b0};
        vecs[18] = '{1, 7'b0000101, 3'd0, 1'b1};
        vecs[19] = '{1, 7'b1100000, 3'd0, 1'b1};

        // Reset.
        rst_n   = 1'b0;
        chk_lat = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_code[d]   = '0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
            chk("rst_out_bin", 32'(out_bin[d]), 32'd0);
            chk("rst_out_err", 32'(out_err[d]), 32'd0);
            chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
        end
`ifdef GOH_DEC_ERR_CNT_EN
        chk("rst_err_cnt_g", 32'(err_cnt_g), 32'd0);
        chk("rst_err_cnt_o", 32'(err_cnt_o), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back sweeps with fixed two-cycle latency.
        chk_lat = 1'b1;
        for (int i = 0; i < 20; i++) drive(vecs[i].dut, vecs[i].code, vecs[i].bin, vecs[i].err);
        drain_check();
        chk_lat = 1'b0;
`ifdef GOH_DEC_ERR_CNT_EN
        chk("err_cnt_g_after_sweep", 32'(err_cnt_g), 32'd2);
        chk("err_cnt_o_after_sweep", 32'(err_cnt_o), 32'd2);
`endif

        // Backpressure on the one-hot instance: illegal word held at the output.
        out_ready[1] = 1'b0;
        drive(1, 7'b0000011, 3'd0, 1'b1);
        drive(1, 7'b0000100, 3'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready_low", 32'(in_ready[1]), 32'd0);
            chk("bp_out_valid", 32'(out_valid[1]), 32'd1);
            chk("bp_out_err", 32'(out_err[1]), 32'd1);
            chk("bp_out_bin", 32'(out_bin[1]), 32'd0);
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready[1] = 1'b1;
        #1;
        chk("bp_in_ready_comb", 32'(in_ready[1]), 32'd1);
        drive(1, 7'b1000000, 3'd7, 1'b0);
        drive(1, 7'b0010000, 3'd5, 1'b0);
        drive(1, 7'b0000001, 3'd1, 1'b0);
        drain_check();
`ifdef GOH_DEC_ERR_CNT_EN
        chk("err_cnt_o_after_bp", 32'(err_cnt_o), 32'd3);
`endif

        // Asynchronous reset with both stages of the gray instance full.
        out_ready[0] = 1'b0;
        drive(0, 7'b0000010, 3'd3, 1'b0);
        drive(0, 7'b0000111, 3'd5, 1'b0);
        chk("pre_rst_out_valid", 32'(out_valid[0]), 32'd1);
        chk("pre_rst_in_ready", 32'(in_ready[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("async_rst_out_bin", 32'(out_bin[0]), 32'd0);
`ifdef GOH_DEC_ERR_CNT_EN
        chk("async_rst_err_cnt_g", 32'(err_cnt_g), 32'd0);
        chk("async_rst_err_cnt_o", 32'(err_cnt_o), 32'd0);
`endif
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        #2;
        rst_n        = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk_lat = 1'b1;
        drive(0, 7'b0000001, 3'd1, 1'b0);
        drain_check();
        chk_lat = 1'b0;

`ifdef GOH_DEC_ERR_CNT_EN
        // Saturation of the 2-bit counter on the gray instance.
        for (int i = 0; i < 5; i++) drive(0, 7'b0100000, 3'd0, 1'b1);
        drain_check();
        chk("err_cnt_sat", 32'(err_cnt_g), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("err_cnt_sat_hold", 32'(err_cnt_g), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_onehot_decoder.md
Name: gray_onehot_decoder

Overview:
- Receiving-end counterpart of the lab's gray/one-hot code generator: accepts a 7-bit code word and recovers the 3-bit binary value.
- Two-stage registered pipeline with valid/ready handshake.
- Flags illegal code words and counts them.
- Sits between a code-word source (generator, link, switch bank) and binary consumers.

Parameters:
- USE_GRAY, 1, 1 = input is 3-bit gray in code[2:0] with code[6:3] zero; 0 = input is the shifted one-hot form (value 0 = all zeros, value k>0 = bit k-1 set).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_code  input  7  code word.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block accepts in_code this cycle.
- out_bin  output  3  decoded binary value.
- out_err  output  1  word carried on out_bin was illegal.
- out_valid  output  1  out_bin/out_err valid.
- out_ready  input  1  downstream accepts this cycle.
- err_cnt  output  CNT_W  saturating count of illegal words delivered (present only with the macro).

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously by design): s1_valid=0, s2_valid=0, out_valid=0, out_bin=0, out_err=0, err_cnt=0.
- Stage 1 registers the raw in_code and valid. Stage 2 registers the decoded value and the error flag.
- Latency is 2 cycles from the accepting edge to out_valid, with no stalls.
- Throughput is 1 word/cycle.
- Handshake:
  - A transfer occurs on a rising edge when valid && ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv.
  - in_ready is combinational from out_ready.
  - While out_valid=1 and out_ready=0, out_bin/out_err/out_valid hold stable.
  - Stage 1 holds while stage 2 is stalled.
- Gray decode (USE_GRAY=1): b2=c2; b1=c2^c1; b0=c2^c1^c0.
  - Error if code[6:3] != 0.
- One-hot decode (USE_GRAY=0):
  - all zeros -> 0.
  - Exactly one bit k set -> k+1.
  - Error if two or more bits are set.
- On error: out_bin=0 and out_err=1.
- Simultaneous events:
  - Accepting a new word while stage 1 forwards to stage 2 in the same cycle is legal and loses nothing.
  - Stage 2 output and a new stage-2 load in the same edge: the new word replaces the old only if out_ready=1.
- No combinational path from in_code to outputs.
- Reset mid-operation: all in-flight words are discarded, no partial output, and the counter clears.

Optional Feature:
- Macro: GOH_DEC_ERR_CNT_EN.
- Defined:
  - err_cnt port exists.
  - Increments by 1 on each output transfer (out_valid && out_ready) with out_err=1.
  - Saturates at all-ones.
  - Not incremented by stalled/held words.
- Undefined:
  - err_cnt port and register are absent.
  - out_err behaviour is unchanged.

Decomposition:
- Shared package gray_onehot_pkg:
  - CODE_W=7, BIN_W=3.
  - Typedefs code_t [6:0] and bin_t [2:0].
  - Functions gray2bin and onehot2bin.
  - The same package serves the generator.
- Sub-module goh_decode_core: pure combinational decode + error check, parameterized by USE_GRAY, instantiated between stage 1 and stage 2.

Test Plan:
- Gray sweep, out_ready=1, back-to-back codes 000,001,011,010,110,111,101,100 -> out_bin 0..7 on consecutive cycles starting 2 cycles after the first accept, out_err=0.
- One-hot sweep (USE_GRAY=0): 0000000,0000001,0000010 ... 1000000 -> out_bin 0..7, out_err=0.
- Illegal words: gray 0001000 -> out_bin=0, out_err=1; one-hot 0000101 -> out_bin=0, out_err=1; with macro, err_cnt=2 after both are accepted downstream.
- Backpressure: stream 5 words, hold out_ready=0 for 4 cycles -> in_ready drops after 2 words are buffered, output is held stable, and no word is lost or duplicated on release.
- Reset mid-stream: drop rst_n asynchronously (between edges) with both stages full -> out_valid=0 immediately, err_cnt=0; first word after release appears 2 cycles after its accept.
- Counter saturation (macro, CNT_W=2): 5 illegal words delivered -> err_cnt is 3 and stays 3.
